board_input_cond: RTL and testbench
===================================

BOARD_INPUT_COND -- requirements
Module: board_input_cond

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 80000, giving clk_i cycles per sample tick (1 ms at 80 MHz).
REQ-002 The block SHALL have parameter STABLE_TICKS, default 4, giving consecutive equal samples needed to accept a new level.
REQ-003 The block SHALL have parameter SW_WIDTH, default 16, giving the switch bus width.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port btn_i, input, 1 bit: raw asynchronous push-button.
REQ-007 The block SHALL have port sw_i, input, SW_WIDTH bits: raw asynchronous slide switches.
REQ-008 The block SHALL have port btn_level_o, output, 1 bit: debounced button level.
REQ-009 The block SHALL have port btn_press_o, output, 1 bit: one-cycle pulse on debounced 0->1 of the button, for the SoC IRQ input.
REQ-010 The block SHALL have port sw_o, output, SW_WIDTH bits: debounced switch levels, for the SoC GPIO input field.
REQ-011 The block SHALL have port sw_change_o, output, 1 bit: one-cycle pulse whenever any sw_o bit changes.

Function
REQ-012 Each raw input bit SHALL pass through its own two-flop synchronizer before any other use.
REQ-013 A shared tick counter SHALL count 0..TICK_DIV-1 and return to 0; tick SHALL be high only in the cycle where the count equals TICK_DIV-1.
REQ-014 Each input bit SHALL have a STABLE_TICKS-bit history register that shifts in the synchronized value only on tick cycles.
REQ-015 On a tick, if the shifted history is all ones the debounced level SHALL become 1, and if it is all zeros the level SHALL become 0.
REQ-016 On a tick with a mixed shifted history, and in all non-tick cycles, the debounced level SHALL hold.
REQ-017 Debounced levels SHALL be registered, visible the cycle after the deciding tick.
REQ-018 btn_press_o SHALL be high for exactly the first cycle in which btn_level_o is 1 after being 0.
REQ-019 A debounced button 1->0 SHALL produce no pulse.
REQ-020 sw_change_o SHALL be high for exactly the first cycle in which sw_o differs from its previous value.
REQ-021 Several sw_o bits changing together SHALL produce a single sw_change_o pulse.
REQ-022 Button and switch paths SHALL be independent; simultaneous button and switch transitions SHALL each produce their own pulse in the same cycle.
REQ-023 Worst-case acceptance latency from a stable raw edge to the output SHALL be at most 2 + STABLE_TICKS*TICK_DIV + 1 cycles.
REQ-024 Any glitch shorter than (STABLE_TICKS-1)*TICK_DIV cycles SHALL never change an output.
REQ-025 The tick counter width SHALL be ceil(log2(TICK_DIV)).
REQ-026 Elaboration SHALL fail if TICK_DIV < 2, or if STABLE_TICKS < 2 or STABLE_TICKS > 16.

Reset
REQ-027 While rst_i is high, all of the following SHALL be 0: synchronizers, tick counter, histories, btn_level_o, btn_press_o, sw_o and sw_change_o.
REQ-028 Reset asserted mid-operation SHALL discard partial histories; no pulse SHALL be emitted during or because of reset.
REQ-029 After reset releases with inputs held high, outputs SHALL rise through normal debounce and emit normal pulses (sw_change_o, btn_press_o).
REQ-030 The first tick after reset release SHALL occur TICK_DIV cycles after release.

Verification (TICK_DIV=4, STABLE_TICKS=3, SW_WIDTH=16)
REQ-031 Clean press scenario:
- Stimulus: btn_i 0->1 and held.
- Response: btn_level_o rises within 15 cycles; btn_press_o is high exactly 1 cycle, coincident with that rise.
- Release then gives btn_level_o 0 within 15 cycles and no pulse.
REQ-032 Bounce scenario:
- Stimulus: btn_i toggled every 3 cycles for 60 cycles, then held 0.
- Response: btn_level_o stays 0 and btn_press_o never asserts.
REQ-033 Multi-bit switch scenario:
- Stimulus: sw_i 16'h0000 -> 16'hA5F0 in one cycle, then held.
- Response: sw_o equals 16'hA5F0 within 15 cycles, and sw_change_o pulses exactly once.
REQ-034 Glitch scenario:
- Stimulus: sw_i[3] high for 7 cycles only.
- Response: sw_o stays 16'h0000 and sw_change_o stays 0.
REQ-035 Simultaneous scenario:
- Stimulus: btn_i and sw_i[0] rise in the same cycle.
- Response: btn_press_o and sw_change_o pulse in the same cycle.
REQ-036 Reset scenario:
- Stimulus: rst_i pulsed for 2 cycles mid-debounce while btn_i is held 1.
- Response: all outputs are 0 during reset; btn_press_o pulses once, no earlier than 12 cycles after release.

Source files
------------

// File: rtl/board_input_cond.sv
// Input conditioning for one push-button and a slide-switch bus: two-flop
// synchronizers, tick-paced history debounce, and one-cycle change pulses.
module board_input_cond #(
   parameter int TICK_DIV     = 80000,
   parameter int STABLE_TICKS = 4,
   parameter int SW_WIDTH     = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                btn_i,
   input  logic [SW_WIDTH-1:0] sw_i,
   output logic                btn_level_o,
   output logic                btn_press_o,
   output logic [SW_WIDTH-1:0] sw_o,
   output logic                sw_change_o
);

   // Button is the top bit of the combined vector, switches below it.
   localparam int N     = SW_WIDTH + 1;
   localparam int CNT_W = $clog2(TICK_DIV);

   generate
      if (TICK_DIV < 2 || STABLE_TICKS < 2 || STABLE_TICKS > 16) begin : g_bad_params
         $error("board_input_cond: TICK_DIV must be >= 2 and STABLE_TICKS within 2..16");
      end
   endgenerate

   logic [N-1:0]                    sync_a;
   logic [N-1:0]                    sync_b;
   logic [CNT_W-1:0]                tick_cnt;
   logic                            tick;
   logic [N-1:0][STABLE_TICKS-1:0]  hist;
   logic [N-1:0][STABLE_TICKS-1:0]  shifted;
   logic [N-1:0]                    level;
   logic [N-1:0]                    next_level;
   logic                            press;
   logic                            change;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {btn_i, sw_i};
         sync_b <= sync_a;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

   // A level only moves when the whole shifted history agrees.
   always_comb begin
      shifted    = '0;
      next_level = level;
      for (int i = 0; i < N; i++) begin
         shifted[i] = {hist[i][STABLE_TICKS-2:0], sync_b[i]};
         if (tick) begin
            if (&shifted[i]) begin
               next_level[i] = 1'b1;
            end else if (~|shifted[i]) begin
               next_level[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist   <= '0;
         level  <= '0;
         press  <= 1'b0;
         change <= 1'b0;
      end else begin
         if (tick) begin
            hist <= shifted;
         end
         level  <= next_level;
         press  <= next_level[N-1] & ~level[N-1];
         change <= (next_level[SW_WIDTH-1:0] != level[SW_WIDTH-1:0]);
      end
   end

   assign btn_level_o = level[N-1];
   assign btn_press_o = press;
   assign sw_o        = level[SW_WIDTH-1:0];
   assign sw_change_o = change;

endmodule

// File: tb/tb_board_input_cond.sv
// Directed bench for board_input_cond at TICK_DIV=4, STABLE_TICKS=3, SW_WIDTH=16.
// Outputs are sampled 1 ns after each rising edge, inputs driven at the same point.
module tb_board_input_cond;

   logic        clk;
   logic        rst;
   logic        btn;
   logic [15:0] sw;
   logic        btn_level;
   logic        btn_press;
   logic [15:0] sw_out;
   logic        sw_change;

   int checks;
   int errors;

   board_input_cond #(
      .TICK_DIV(4),
      .STABLE_TICKS(3),
      .SW_WIDTH(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .btn_i(btn),
      .sw_i(sw),
      .btn_level_o(btn_level),
      .btn_press_o(btn_press),
      .sw_o(sw_out),
      .sw_change_o(sw_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int press_cnt;
      int change_cnt;
      int press_idx;
      int change_idx;
      rst = 1'b1;
      btn = 1'b1;
      sw  = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({btn_level, btn_press, sw_out, sw_change} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_hold: outputs=%h expected=0", {btn_level, btn_press, sw_out, sw_change});
         end
      end
      rst = 1'b0;
      press_cnt = 0; change_cnt = 0; press_idx = -1; change_idx = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (btn_press) begin
            press_cnt++;
            if (press_idx < 0) press_idx = i;
         end
         if (sw_change) begin
            change_cnt++;
            if (change_idx < 0) change_idx = i;
         end
      end
      checks++;
      if (press_idx !== 12 || press_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL reset_release_press: idx=%0d count=%0d expected idx=12 count=1", press_idx, press_cnt);
      end
      checks++;
      if (change_idx !== 12 || change_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL reset_release_change: idx=%0d count=%0d expected idx=12 count=1", change_idx, change_cnt);
      end
      checks++;
      if (btn_level !== 1'b1 || sw_out !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL reset_release_levels: btn=%b sw=%h expected btn=1 sw=ffff", btn_level, sw_out);
      end
      // Drop everything back to idle; falling button must not pulse.
      btn = 1'b0;
      sw  = 16'h0000;
      press_cnt = 0; change_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (btn_press) press_cnt++;
         if (sw_change) change_cnt++;
      end
      checks++;
      if (press_cnt !== 0 || change_cnt !== 1 || btn_level !== 1'b0 || sw_out !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL idle_return: press=%0d change=%0d btn=%b sw=%h expected 0 1 0 0000",
                  press_cnt, change_cnt, btn_level, sw_out);
      end
   endtask

   task automatic test_clean_press();
      int press_cnt;
      int press_idx;
      int rise_idx;
      logic prev;
      btn = 1'b1;
      press_cnt = 0; press_idx = -1; rise_idx = -1; prev = btn_level;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (btn_press) begin
            press_cnt++;
            if (press_idx < 0) press_idx = i;
         end
         if (btn_level && !prev && rise_idx < 0) rise_idx = i;
         prev = btn_level;
      end
      checks++;
      if (btn_level !== 1'b1 || rise_idx < 0) begin
         errors++;
         $display("[TB] FAIL press_level: level=%b rise_idx=%0d expected level=1 within 15", btn_level, rise_idx);
      end
      checks++;
      if (press_cnt !== 1 || press_idx !== rise_idx) begin
         errors++;
         $display("[TB] FAIL press_pulse: count=%0d idx=%0d expected count=1 idx=%0d", press_cnt, press_idx, rise_idx);
      end
      btn = 1'b0;
      press_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (btn_press) press_cnt++;
      end
      checks++;
      if (btn_level !== 1'b0 || press_cnt !== 0) begin
         errors++;
         $display("[TB] FAIL release: level=%b pulses=%0d expected level=0 pulses=0", btn_level, press_cnt);
      end
   endtask

   task automatic test_bounce();
      int bad;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         btn = ((i / 3) % 2 == 0);
         step();
         if (btn_level !== 1'b0 || btn_press !== 1'b0) bad++;
      end
      btn = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (btn_level !== 1'b0 || btn_press !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("[TB] FAIL bounce: bad_cycles=%0d expected 0", bad);
      end
   endtask

   task automatic test_switch_multi();
      int change_cnt;
      sw = 16'hA5F0;
      change_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (sw_change) change_cnt++;
      end
      checks++;
      if (sw_out !== 16'hA5F0) begin
         errors++;
         $display("[TB] FAIL switch_value: sw=%h expected a5f0", sw_out);
      end
      checks++;
      if (change_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL switch_pulse: count=%0d expected 1", change_cnt);
      end
      sw = 16'h0000;
      change_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (sw_change) change_cnt++;
      end
      checks++;
      if (sw_out !== 16'h0000 || change_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL switch_clear: sw=%h count=%0d expected 0000 1", sw_out, change_cnt);
      end
   endtask

   task automatic test_glitch();
      int bad;
      bad = 0;
      sw[3] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if (sw_out !== 16'h0000 || sw_change !== 1'b0) bad++;
      end
      sw[3] = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (sw_out !== 16'h0000 || sw_change !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("[TB] FAIL glitch: bad_cycles=%0d sw=%h expected 0 0000", bad, sw_out);
      end
   endtask

   task automatic test_simultaneous();
      int press_idx;
      int change_idx;
      int press_cnt;
      int change_cnt;
      btn = 1'b1;
      sw[0] = 1'b1;
      press_idx = -1; change_idx = -1; press_cnt = 0; change_cnt = 0;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (btn_press) begin
            press_cnt++;
            if (press_idx < 0) press_idx = i;
         end
         if (sw_change) begin
            change_cnt++;
            if (change_idx < 0) change_idx = i;
         end
      end
      checks++;
      if (press_cnt !== 1 || change_cnt !== 1 || press_idx !== change_idx) begin
         errors++;
         $display("[TB] FAIL simultaneous: press=%0d@%0d change=%0d@%0d expected one each in same cycle",
                  press_cnt, press_idx, change_cnt, change_idx);
      end
      btn = 1'b0;
      sw  = 16'h0000;
      for (int i = 0; i < 15; i++) step();
   endtask

   task automatic test_reset_mid();
      int press_cnt;
      int press_idx;
      int early;
      btn = 1'b1;
      early = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (btn_press || btn_level) early++;
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({btn_level, btn_press, sw_out, sw_change} !== 19'd0 || early !== 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_hold: outputs=%h early=%0d expected 0 0",
                     {btn_level, btn_press, sw_out, sw_change}, early);
         end
      end
      rst = 1'b0;
      press_cnt = 0; press_idx = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (btn_press) begin
            press_cnt++;
            if (press_idx < 0) press_idx = i;
         end
      end
      checks++;
      if (press_cnt !== 1 || press_idx < 12 || btn_level !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_reset_release: count=%0d idx=%0d level=%b expected 1 >=12 1",
                  press_cnt, press_idx, btn_level);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      btn = 1'b0;
      sw  = 16'h0000;
      test_reset();
      test_clean_press();
      test_bounce();
      test_switch_multi();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
